dac124_spi_tx: RTL and testbench

Serial transmitter for the DAC124S085 quad 12-bit DAC, directly downstream of the DAC124 command sequencer. Accepts one 16-bit command word per CONFIG_EN/CONFIG_END handshake and shifts it MSB-first onto the DAC's 3-wire interface (SYNC_N/SCLK/DIN). Pulses CONFIG_END once the frame has closed, so the sequencer can advance to its next word.

---
 rtl/dac124_pkg.sv | 21 ++
 rtl/dac124_div_tick.sv | 37 +++
 rtl/dac124_spi_tx.sv | 163 ++++++++++++++++
 tb/tb_dac124_spi_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac124_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac124_pkg
//  Description : Shared types and widths for the DAC124S085 serial transmitter
//  Revision    : 1.0  initial release
// ============================================================================
package dac124_pkg;

   localparam int DAC124_WORD_W    = 16;
   localparam int DAC124_BIT_CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LEAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      GAP      = 3'd4
   } dac124_state_t;

endpackage
`default_nettype wire

// File: rtl/dac124_div_tick.sv
`default_nettype none
// ============================================================================
//  Module      : dac124_div_tick
//  Description : Half-period timer; one-cycle tick every CLK_DIV clocks,
//                restarted whenever the transmitter enters a new state
//  Revision    : 1.0  initial release
// ============================================================================
module dac124_div_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int                 CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count system clocks inside the current half-period; restart on state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Tick on the last clock of the half-period so the FSM moves on the next edge
   assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/dac124_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac124_spi_tx
//  Description : Shifts one 16-bit command word per request onto the
//                DAC124S085 SYNC_N/SCLK/DIN interface, MSB first, and pulses
//                config_end when the frame has closed
//  Revision    : 1.0  initial release
// ============================================================================
module dac124_spi_tx
   import dac124_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int SYNC_GAP = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     config_en,
   input  logic [DAC124_WORD_W-1:0] config_data,
   output logic                     config_end,
   output logic                     busy,
   output logic                     dac_sync_n,
   output logic                     dac_sclk,
   output logic                     dac_din
);

   generate
      if (CLK_DIV < 2) begin : g_bad_clk_div
         $error("dac124_spi_tx: CLK_DIV must be >= 2");
      end
      if (SYNC_GAP < 1) begin : g_bad_sync_gap
         $error("dac124_spi_tx: SYNC_GAP must be >= 1");
      end
   endgenerate

   localparam int               GAP_W    = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

   dac124_state_t               state_q,   state_d;
   logic [DAC124_WORD_W-1:0]    shreg_q,   shreg_d;
   logic [DAC124_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
   logic                        sync_n_q,  sync_n_d;
   logic                        sclk_q,    sclk_d;
   logic                        din_q,     din_d;
   logic                        end_q,     end_d;
   logic                        busy_q,    busy_d;
   logic                        tick;
   logic                        state_entry;

   // Timer restarts on every state change so each phase lasts exactly CLK_DIV clocks
   assign state_entry = (state_d != state_q);

   dac124_div_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_div_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_entry),
      .tick  (tick)
   );

   // State and registered-output flops; reset drives the DAC pins idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         sync_n_q  <= 1'b1;
         sclk_q    <= 1'b1;
         din_q     <= 1'b0;
         end_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sync_n_q  <= sync_n_d;
         sclk_q    <= sclk_d;
         din_q     <= din_d;
         end_q     <= end_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state and next-output logic; pins only change on phase boundaries
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sync_n_d  = sync_n_q;
      sclk_d    = sclk_q;
      din_d     = din_q;
      end_d     = 1'b0;
      busy_d    = busy_q;

      unique case (state_q)
         IDLE: begin
            if (config_en) begin
               state_d   = LEAD;
               shreg_d   = config_data;
               bit_cnt_d = '0;
               sync_n_d  = 1'b0;
               sclk_d    = 1'b1;
               din_d     = config_data[DAC124_WORD_W-1];
               busy_d    = 1'b1;
            end
         end
         LEAD: begin
            if (tick) begin
               state_d = SHIFT_LO;
               sclk_d  = 1'b0;
            end
         end
         SHIFT_LO: begin
            // Rising SCLK: DAC has sampled the current bit, present the next one
            if (tick) begin
               state_d   = SHIFT_HI;
               sclk_d    = 1'b1;
               shreg_d   = {shreg_q[DAC124_WORD_W-2:0], 1'b0};
               din_d     = (bit_cnt_q == {DAC124_BIT_CNT_W{1'b1}}) ? 1'b0
                                                                   : shreg_q[DAC124_WORD_W-2];
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            // Counter has wrapped after the 16th rising edge: close the frame
            if (tick) begin
               if (bit_cnt_q == '0) begin
                  state_d   = GAP;
                  sync_n_d  = 1'b1;
                  end_d     = 1'b1;
                  gap_cnt_d = '0;
               end else begin
                  state_d = SHIFT_LO;
                  sclk_d  = 1'b0;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign config_end = end_q;
   assign busy       = busy_q;
   assign dac_sync_n = sync_n_q;
   assign dac_sclk   = sclk_q;
   assign dac_din    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_dac124_spi_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dac124_spi_tx
//  Description : Scoreboard bench for dac124_spi_tx (default divider plus a
//                CLK_DIV=2 / SYNC_GAP=1 instance)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac124_spi_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        config_en;
   logic [15:0] config_data;
   logic        config_end, busy, dac_sync_n, dac_sclk, dac_din;

   logic        en2;
   logic [15:0] data2;
   logic        end2, busy2, sync2, sclk2, din2;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac124_spi_tx #(.CLK_DIV(4), .SYNC_GAP(2)) dut (
      .clk(clk), .rst(rst), .config_en(config_en), .config_data(config_data),
      .config_end(config_end), .busy(busy), .dac_sync_n(dac_sync_n),
      .dac_sclk(dac_sclk), .dac_din(dac_din)
   );

   dac124_spi_tx #(.CLK_DIV(2), .SYNC_GAP(1)) dut2 (
      .clk(clk), .rst(rst), .config_en(en2), .config_data(data2),
      .config_end(end2), .busy(busy2), .dac_sync_n(sync2),
      .dac_sclk(sclk2), .dac_din(din2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / monitor for the default instance ----------
   logic [15:0] exp_q[$];
   int          start_log[$];
   logic [15:0] rx_bits = '0;
   int          n_fall = 0, start_cyc = 0, end_cnt = 0;
   logic        p_sclk = 1'b1, p_din = 1'b0, p_sync = 1'b1, p_busy = 1'b0, p_end = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         n_fall = 0; p_sclk = 1'b1; p_din = 1'b0; p_sync = 1'b1; p_busy = 1'b0; p_end = 1'b0;
      end else begin
         if (p_sync && !dac_sync_n) begin
            start_cyc = cyc;
            n_fall    = 0;
            start_log.push_back(cyc);
            check_eq("busy_at_start", busy, 1);
         end
         if (p_sclk && !dac_sclk) begin
            rx_bits = {rx_bits[14:0], dac_din};
            n_fall++;
         end
         if (dac_din != p_din)
            check_eq("din_change_on_rise", (dac_sclk && !p_sclk) || (!dac_sync_n && p_sync), 1);
         if (dac_sync_n && busy) begin
            check_eq("gap_din", dac_din, 0);
            check_eq("gap_sclk", dac_sclk, 1);
         end
         if (config_end) begin
            end_cnt++;
            check_eq("end_width", p_end, 0);
            check_eq("end_falls", n_fall, 16);
            check_eq("end_cycle", cyc - start_cyc, 132);
            check_eq("end_sync_n", dac_sync_n, 1);
            if (exp_q.size() > 0) check_eq("rx_word", rx_bits, exp_q.pop_front());
            else                  check_eq("sb_underflow", exp_q.size(), 1);
         end
         if (p_busy && !busy)
            check_eq("busy_low_cycle", cyc - start_cyc, 134);
         p_sclk = dac_sclk; p_din = dac_din; p_sync = dac_sync_n; p_busy = busy; p_end = config_end;
      end
   end

   // ---------------- scoreboard / monitor for the CLK_DIV=2 instance --------
   logic [15:0] exp2_q[$];
   logic [15:0] rx2 = '0;
   int          n2 = 0, s2 = 0, last_fall2 = 0, end2_cnt = 0;
   logic        p2_sclk = 1'b1, p2_din = 1'b0, p2_sync = 1'b1, p2_busy = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (p2_sync && !sync2) begin s2 = cyc; n2 = 0; end
         if (p2_sclk && !sclk2) begin
            rx2 = {rx2[14:0], din2};
            n2++;
            if (n2 > 1) check_eq("sclk2_period", cyc - last_fall2, 4);
            last_fall2 = cyc;
         end
         if (din2 != p2_din)
            check_eq("din2_change_on_rise", (sclk2 && !p2_sclk) || (!sync2 && p2_sync), 1);
         if (end2) begin
            end2_cnt++;
            check_eq("end2_falls", n2, 16);
            check_eq("end2_cycle", cyc - s2, 66);
            if (exp2_q.size() > 0) check_eq("rx2_word", rx2, exp2_q.pop_front());
            else                   check_eq("sb2_underflow", exp2_q.size(), 1);
         end
         if (p2_busy && !busy2) check_eq("busy2_low_cycle", cyc - s2, 67);
         p2_sclk = sclk2; p2_din = din2; p2_sync = sync2; p2_busy = busy2;
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_start();
      for (int i = 0; i < 20 && dac_sync_n; i++) @(negedge clk);
      check_eq("start_timeout", dac_sync_n, 0);
   endtask

   // Present a word, scramble the data bus mid-frame, wait for the frame end;
   // optionally mimic the sequencer's one-cycle request drop after config_end.
   task automatic send_word(input logic [15:0] w, input bit drop);
      config_data = w;
      config_en   = 1'b1;
      exp_q.push_back(w);
      wait_start();
      config_data = 16'($urandom);
      for (int i = 0; i < 300 && !config_end; i++) @(negedge clk);
      check_eq("end_timeout", config_end, 1);
      if (drop) begin
         config_en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      check_eq("idle_timeout", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_sync_n"}, dac_sync_n, 1);
      check_eq({tag, "_sclk"},   dac_sclk,   1);
      check_eq({tag, "_din"},    dac_din,    0);
      check_eq({tag, "_busy"},   busy,       0);
      check_eq({tag, "_end"},    config_end, 0);
   endtask

   logic [15:0] seq_words[4] = '{16'h4BB8, 16'h1BB8, 16'hCBB8, 16'h9BB8};

   initial begin
      int base;
      int ends_before;

      rst = 1'b1; config_en = 1'b0; config_data = '0; en2 = 1'b0; data2 = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // single word, defaults
      send_word(16'h4BB8, 1'b1);
      config_en = 1'b0;
      wait_idle();
      check_eq("single_end_count", end_cnt, 1);

      // sequencer-style stream of four words, request held across frames
      base = start_log.size();
      for (int i = 0; i < 4; i++) send_word(seq_words[i], 1'b1);
      config_en = 1'b0;
      wait_idle();
      for (int i = 1; i < 4; i++)
         check_eq("seq_frame_period", start_log[base+i] - start_log[base+i-1], 135);
      check_eq("seq_end_count", end_cnt, 5);

      // all-ones then all-zeros back to back
      base = start_log.size();
      send_word(16'hFFFF, 1'b1);
      send_word(16'h0000, 1'b1);
      config_en = 1'b0;
      wait_idle();
      check_eq("ff00_frame_period", start_log[base+1] - start_log[base], 135);

      // reset in the middle of a frame
      ends_before = end_cnt;
      config_data = 16'hA5C3;
      config_en   = 1'b1;
      wait_start();
      config_en = 1'b0;
      for (int i = 0; i < 100 && cyc < start_cyc + 50; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("abort");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_eq("abort_no_end", end_cnt, ends_before);
      repeat (2) @(negedge clk);
      send_word(16'h3C5A, 1'b1);
      config_en = 1'b0;
      wait_idle();

      // CLK_DIV=2, SYNC_GAP=1 instance
      data2 = 16'hA35C; en2 = 1'b1; exp2_q.push_back(16'hA35C);
      for (int i = 0; i < 20 && sync2; i++) @(negedge clk);
      check_eq("start2_timeout", sync2, 0);
      en2 = 1'b0; data2 = 16'h0001;
      for (int i = 0; i < 100 && busy2; i++) @(negedge clk);
      check_eq("idle2_timeout", busy2, 0);
      en2 = 1'b1; exp2_q.push_back(16'h0001);
      for (int i = 0; i < 20 && sync2; i++) @(negedge clk);
      en2 = 1'b0;
      for (int i = 0; i < 100 && busy2; i++) @(negedge clk);
      check_eq("idle2b_timeout", busy2, 0);
      repeat (2) @(negedge clk);

      check_eq("total_end_count", end_cnt, 8);
      check_eq("total_end2_count", end2_cnt, 2);
      check_eq("sb_left", exp_q.size(), 0);
      check_eq("sb2_left", exp2_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
